// File: rtl/uart_tx.sv
// uart_tx: configurable UART transmitter (start, 1-8 data bits MSB-first, optional parity, 1-3 stop bits)
module uart_tx #(
    parameter int SAMPLE_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [3:0]              data_width,
    input  logic [1:0]              stop_bits,
    input  logic [1:0]              parity,
    input  logic [SAMPLE_WIDTH-1:0] samples_per_bit,
    input  logic [7:0]              tx_data,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    output logic                    tx_out,
    output logic                    busy,
    output logic [3:0]              state_o
);
    typedef enum logic [3:0] {IDLE = 4'd0, START = 4'd1, DATA = 4'd2, PARITY = 4'd3, STOP = 4'd4} state_t;
    state_t                  state_q;
    logic [7:0]              data_q;
    logic [2:0]              wm1_q, bit_q;
    logic [1:0]              sm1_q;
    logic                    par_en_q, par_odd_q, tx_q, busy_q;
    logic [SAMPLE_WIDTH-1:0] spb_q, cnt_q;
    logic [2:0]              wm1_d, bit_d;
    logic [1:0]              sm1_d;
    logic                    par_bit, period_end;
    assign wm1_d      = (data_width == 4'd0 || data_width > 4'd8) ? 3'd7 : 3'(data_width - 4'd1);
    assign sm1_d      = (stop_bits == 2'd0) ? 2'd0 : stop_bits - 2'd1;
    assign bit_d      = bit_q - 3'd1;
    // only the W active data bits take part in parity
    assign par_bit    = (^(data_q & (8'hFF >> (3'd7 - wm1_q)))) ^ par_odd_q;
    assign period_end = cnt_q == '0;
    assign tx_ready   = state_q == IDLE && enable && reset;
    assign tx_out     = tx_q;
    assign busy       = busy_q;
    assign state_o    = state_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            data_q    <= '0;
            wm1_q     <= '0;
            bit_q     <= '0;
            sm1_q     <= '0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            spb_q     <= '0;
            cnt_q     <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            cnt_q <= period_end ? spb_q : cnt_q - 1'b1;
            case (state_q)
                IDLE: if (tx_valid && enable) begin
                    state_q   <= START;
                    data_q    <= tx_data;
                    wm1_q     <= wm1_d;
                    sm1_q     <= sm1_d;
                    par_en_q  <= parity == 2'd1 || parity == 2'd2;
                    par_odd_q <= parity == 2'd1;
                    spb_q     <= samples_per_bit;
                    cnt_q     <= samples_per_bit;
                    tx_q      <= 1'b0;
                    busy_q    <= 1'b1;
                end
                START: if (period_end) begin
                    state_q <= DATA;
                    bit_q   <= wm1_q;
                    tx_q    <= data_q[wm1_q];
                end
                DATA: if (period_end) begin
                    if (bit_q != 3'd0) begin
                        bit_q <= bit_d;
                        tx_q  <= data_q[bit_d];
                    end else if (par_en_q) begin
                        state_q <= PARITY;
                        tx_q    <= par_bit;
                    end else begin
                        state_q <= STOP;
                        bit_q   <= {1'b0, sm1_q};
                        tx_q    <= 1'b1;
                    end
                end
                PARITY: if (period_end) begin
                    state_q <= STOP;
                    bit_q   <= {1'b0, sm1_q};
                    tx_q    <= 1'b1;
                end
                STOP: if (period_end) begin
                    if (bit_q == 3'd0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        bit_q <= bit_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx with a simple serial receiver model
module tb_uart_tx;
    logic        clk = 1'b0, reset = 1'b0, enable = 1'b1;
    logic [3:0]  data_width = 4'd8;
    logic [1:0]  stop_bits = 2'd1, parity = 2'd0;
    logic [31:0] samples_per_bit = '0;
    logic [7:0]  tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready, tx_out, busy;
    logic [3:0]  state_o;
    int checks = 0, errors = 0;

    uart_tx #(.SAMPLE_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .enable(enable), .data_width(data_width),
        .stop_bits(stop_bits), .parity(parity), .samples_per_bit(samples_per_bit),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_out(tx_out), .busy(busy), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic [3:0] w, input logic [1:0] st,
                        input logic [1:0] par, input int spb, input bit hold);
        @(negedge clk);
        tx_data = d; data_width = w; stop_bits = st; parity = par;
        samples_per_bit = spb; tx_valid = 1'b1;
        check("ready_before_accept", {31'd0, tx_ready}, 1);
        check("line_before_accept", {31'd0, tx_out}, 1);
        @(posedge clk);
        #1 if (!hold) tx_valid = 1'b0;
    endtask

    task automatic capture(input int nbits, input int spb, output logic [31:0] bits,
                           output int busy_n, output int glitch);
        logic first;
        bits = '0; busy_n = 0; glitch = 0; first = 1'b0;
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c <= spb; c++) begin
                @(negedge clk);
                if (busy) busy_n++;
                if (c == 0) first = tx_out;
                else if (tx_out !== first) glitch++;
            end
            bits = {bits[30:0], first};
        end
    endtask

    task automatic frame(input string tag, input logic [7:0] d, input logic [3:0] w,
                         input logic [1:0] st, input logic [1:0] par, input int spb,
                         input int nbits, input logic [31:0] exp);
        logic [31:0] bits;
        int bn, gl;
        send(d, w, st, par, spb, 1'b0);
        capture(nbits, spb, bits, bn, gl);
        check({tag, "_bits"}, bits, exp);
        check({tag, "_busy_cycles"}, bn, nbits * (spb + 1));
        check({tag, "_stable"}, gl, 0);
        @(negedge clk);
        check({tag, "_end"}, {26'd0, busy, tx_out, state_o}, 32'b010000);
    endtask

    task automatic rx(output logic [7:0] d, output logic p, output logic s,
                      output logic st0, output logic to);
        int n = 0;
        d = '0;
        while (tx_out !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        to = n >= 100;
        repeat (5) @(negedge clk);
        st0 = tx_out;
        for (int i = 0; i < 8; i++) begin
            repeat (10) @(negedge clk);
            d = {d[6:0], tx_out};
        end
        repeat (10) @(negedge clk);
        p = tx_out;
        repeat (10) @(negedge clk);
        s = tx_out;
        n = 0;
        while (busy && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) to = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] bits;
        int bn, gl, bad;
        logic [7:0] rd, lb[4];
        logic rp, rs, rst0, rto;
        lb = '{8'h00, 8'hFF, 8'h5A, 8'hC3};
        #12;
        check("reset_state", {25'd0, tx_out, busy, tx_ready, state_o}, 32'b1000000);
        @(negedge clk) reset = 1'b1;

        frame("a5", 8'hA5, 4'd8, 2'd1, 2'd0, 3, 10, 32'b0101001011);
        frame("even", 8'h1B, 4'd5, 2'd2, 2'd2, 0, 9, 32'b011011011);
        frame("odd", 8'h1B, 4'd5, 2'd2, 2'd1, 0, 9, 32'b011011111);
        frame("w0", 8'h81, 4'd0, 2'd0, 2'd0, 2, 10, 32'b0100000011);
        frame("w12", 8'h81, 4'd12, 2'd0, 2'd0, 2, 10, 32'b0100000011);
        frame("stop3_par3", 8'h81, 4'd12, 2'd3, 2'd3, 0, 12, 32'b010000001111);

        send(8'h3C, 4'd8, 2'd1, 2'd0, 1, 1'b1);
        fork
            capture(10, 1, bits, bn, gl);
            begin @(negedge clk); tx_data = 8'hC3; data_width = 4'd4; parity = 2'd2; end
        join
        check("b2b1_bits", bits, 32'b0001111001);
        check("b2b1_busy_cycles", bn, 20);
        check("b2b1_stable", gl, 0);
        @(negedge clk);
        check("b2b_gap", {29'd0, tx_out, busy, tx_ready}, 32'b101);
        fork
            capture(7, 1, bits, bn, gl);
            begin @(posedge clk); #1 tx_valid = 1'b0; end
        join
        check("b2b2_bits", bits, 32'b0001101);
        check("b2b2_busy_cycles", bn, 14);
        check("b2b2_stable", gl, 0);
        @(negedge clk);
        check("b2b2_end", {26'd0, busy, tx_out, state_o}, 32'b010000);

        send(8'h00, 4'd8, 2'd1, 2'd0, 3, 1'b0);
        repeat (8) @(negedge clk);
        check("pre_reset", {27'd0, tx_out, state_o}, 32'b00010);
        #2 reset = 1'b0;
        #1 check("mid_reset", {25'd0, tx_out, busy, tx_ready, state_o}, 32'b1000000);
        @(negedge clk) reset = 1'b1;
        frame("post_reset", 8'hA5, 4'd8, 2'd1, 2'd0, 0, 10, 32'b0101001011);

        @(negedge clk);
        enable = 1'b0; tx_valid = 1'b1; bad = 0;
        repeat (6) begin @(negedge clk); if (tx_ready || !tx_out || busy) bad++; end
        check("disabled_idle", bad, 0);
        tx_valid = 1'b0; enable = 1'b1;
        send(8'h55, 4'd8, 2'd1, 2'd0, 1, 1'b0);
        fork
            capture(10, 1, bits, bn, gl);
            begin @(negedge clk); enable = 1'b0; tx_valid = 1'b1; end
        join
        check("en_drop_bits", bits, 32'b0010101011);
        check("en_drop_busy_cycles", bn, 20);
        bad = 0;
        repeat (6) begin @(negedge clk); if (tx_ready || !tx_out || busy || state_o != 4'd0) bad++; end
        check("en_drop_no_accept", bad, 0);
        tx_valid = 1'b0; enable = 1'b1;

        for (int i = 0; i < 4; i++) begin
            fork
                send(lb[i], 4'd8, 2'd1, 2'd2, 9, 1'b0);
                rx(rd, rp, rs, rst0, rto);
            join
            check("loop_data", {24'd0, rd}, {24'd0, lb[i]});
            check("loop_frame", {28'd0, rto, rst0, rp, rs}, {28'd0, 1'b0, 1'b0, ^lb[i], 1'b1});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
